// File: rtl/rv_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32 control unit: FSM states, opcode/funct
// fields, ALU operation codes and datapath mux selects.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADR,
        S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JAL, S_TRAP
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_SLL = 3'd3;
    localparam logic [2:0] ALU_CMP = 3'd4;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;
    localparam logic [1:0] SRCB_RS2   = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] IMM_I      = 2'd0;
    localparam logic [1:0] IMM_S      = 2'd1;
    localparam logic [1:0] IMM_B      = 2'd2;
    localparam logic [1:0] IMM_J      = 2'd3;
    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

endpackage

// File: rtl/rv_ctrl_fsm_if.sv
// Control-unit <-> datapath/memory bundle. master = control unit, slave = datapath side.
interface rv_ctrl_fsm_if #(
    parameter int ALUC_W = 3
);
    // mem_req is raised by the master and held, with adr_src/mem_we stable, until a
    // cycle where mem_ready is also high; that cycle completes the transfer.
    logic [31:0]       instr;
    logic              mem_ready;
    logic              alu_zero;
    logic              mem_req;
    logic              mem_we;
    logic              adr_src;
    logic              ir_we;
    logic              pc_we;
    logic              reg_we;
    logic [ALUC_W-1:0] alu_control;
    logic [1:0]        alu_src_a;
    logic [1:0]        alu_src_b;
    logic [1:0]        imm_sel;
    logic [1:0]        result_src;
    logic              illegal;
    logic              bus_err;

    modport master (
        input  instr, mem_ready, alu_zero,
        output mem_req, mem_we, adr_src, ir_we, pc_we, reg_we, alu_control,
               alu_src_a, alu_src_b, imm_sel, result_src, illegal, bus_err
    );

    modport slave (
        output instr, mem_ready, alu_zero,
        input  mem_req, mem_we, adr_src, ir_we, pc_we, reg_we, alu_control,
               alu_src_a, alu_src_b, imm_sel, result_src, illegal, bus_err
    );
endinterface

// File: rtl/rv_ctrl_fsm_decode.sv
// Combinational instruction classifier: picks the post-DECODE state, ALU op and
// immediate format, and flags encodings outside the supported subset.
module rv_instr_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output state_e     exec_state_o,
    output logic [2:0] alu_op_o,
    output logic [1:0] imm_sel_o,
    output logic       legal_o
);
    always_comb begin
        exec_state_o = S_TRAP;
        alu_op_o     = ALU_ADD;
        imm_sel_o    = IMM_I;
        legal_o      = 1'b0;
        case (opcode_i)
            OP_R: begin
                exec_state_o = S_EXEC_R;
                legal_o      = 1'b1;
                if (funct7_i == F7_ZERO && funct3_i == F3_ADD)      alu_op_o = ALU_ADD;
                else if (funct7_i == F7_SUB && funct3_i == F3_ADD)  alu_op_o = ALU_SUB;
                else if (funct7_i == F7_ZERO && funct3_i == F3_AND) alu_op_o = ALU_AND;
                else if (funct7_i == F7_ZERO && funct3_i == F3_SLL) alu_op_o = ALU_SLL;
                else legal_o = 1'b0;
            end
            OP_IMM: begin
                exec_state_o = S_EXEC_I;
                legal_o      = 1'b1;
                if (funct3_i == F3_ADD)                             alu_op_o = ALU_ADD;
                else if (funct3_i == F3_AND)                        alu_op_o = ALU_AND;
                else if (funct3_i == F3_SLL && funct7_i == F7_ZERO) alu_op_o = ALU_SLL;
                else legal_o = 1'b0;
            end
            OP_LOAD: begin
                exec_state_o = S_MEM_ADR;
                legal_o      = (funct3_i == F3_WORD);
            end
            OP_STORE: begin
                exec_state_o = S_MEM_ADR;
                imm_sel_o    = IMM_S;
                legal_o      = (funct3_i == F3_WORD);
            end
            OP_BRANCH: begin
                exec_state_o = S_BRANCH;
                alu_op_o     = ALU_SUB;
                legal_o      = (funct3_i == F3_BEQ) || (funct3_i == F3_BNE);
            end
            OP_JAL: begin
                exec_state_o = S_JAL;
                legal_o      = 1'b1;
            end
            default: legal_o = 1'b0;
        endcase
        if (!legal_o) exec_state_o = S_TRAP;
    end
endmodule

// File: rtl/rv_ctrl_fsm.sv
// Multi-cycle RV32 control FSM: sequences fetch/decode/execute/memory/writeback and
// traps on illegal encodings or memory requests that never complete.
module rv_ctrl_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 255,
    parameter int ALUC_W     = 3
) (
    input  logic          clk,
    input  logic          rst,
    rv_ctrl_fsm_if.master bus,
    output state_e        state_o
);
    state_e     state_q, state_d, dec_state;
    logic [7:0] wait_q, wait_d;
    logic       illegal_q, illegal_d, bus_err_q, bus_err_d;
    logic [2:0] dec_alu_op, alu_op;
    logic [1:0] dec_imm_sel, src_a, src_b, imm_sel, res_src;
    logic       dec_legal, mem_wait, timeout;
    logic       mem_req, mem_we, adr_src, ir_we, pc_we, reg_we;
    logic       unused_instr_bits;

    rv_instr_decode u_decode (
        .opcode_i     (bus.instr[6:0]),
        .funct3_i     (bus.instr[14:12]),
        .funct7_i     (bus.instr[31:25]),
        .exec_state_o (dec_state),
        .alu_op_o     (dec_alu_op),
        .imm_sel_o    (dec_imm_sel),
        .legal_o      (dec_legal)
    );

    assign unused_instr_bits = ^{bus.instr[24:15], bus.instr[11:7]};

    // A completing mem_ready always beats the limit in the same cycle.
    assign mem_wait = (state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR)
                      && !bus.mem_ready;
    assign timeout  = mem_wait && (({1'b0, wait_q} + 9'd1) >= 9'(WAIT_LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        adr_src   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        reg_we    = 1'b0;
        alu_op    = ALU_ADD;
        src_a     = SRCA_PC;
        src_b     = SRCB_RS2;
        imm_sel   = IMM_I;
        res_src   = RES_ALUOUT;
        if (timeout) begin
            state_d   = S_TRAP;
            bus_err_d = 1'b1;
        end else if (mem_wait) begin
            wait_d = wait_q + 8'd1;
        end
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    src_b   = SRCB_FOUR;
                    res_src = RES_ALU;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                src_a     = SRCA_OLDPC;
                src_b     = SRCB_IMM;
                imm_sel   = (bus.instr[6:0] == OP_JAL) ? IMM_J : IMM_B;
                state_d   = dec_state;
                illegal_d = !dec_legal;
            end
            S_EXEC_R: begin
                src_a   = SRCA_RS1;
                alu_op  = dec_alu_op;
                state_d = S_ALU_WB;
            end
            S_EXEC_I: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_IMM;
                alu_op  = dec_alu_op;
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_we  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEM_ADR: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_IMM;
                imm_sel = dec_imm_sel;
                state_d = (bus.instr[6:0] == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (bus.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_we  = 1'b1;
                res_src = RES_MEM;
                state_d = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_BRANCH: begin
                src_a   = SRCA_RS1;
                alu_op  = ALU_SUB;
                pc_we   = bus.alu_zero ^ bus.instr[12];
                state_d = S_FETCH;
            end
            S_JAL: begin
                pc_we   = 1'b1;
                src_a   = SRCA_OLDPC;
                src_b   = SRCB_FOUR;
                state_d = S_ALU_WB;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    assign bus.mem_req     = mem_req & ~rst;
    assign bus.mem_we      = mem_we & ~rst;
    assign bus.adr_src     = adr_src & ~rst;
    assign bus.ir_we       = ir_we & ~rst;
    assign bus.pc_we       = pc_we & ~rst;
    assign bus.reg_we      = reg_we & ~rst;
    assign bus.alu_control = rst ? '0 : ALUC_W'(alu_op);
    assign bus.alu_src_a   = rst ? '0 : src_a;
    assign bus.alu_src_b   = rst ? '0 : src_b;
    assign bus.imm_sel     = rst ? '0 : imm_sel;
    assign bus.result_src  = rst ? '0 : res_src;
    assign bus.illegal     = illegal_q & ~rst;
    assign bus.bus_err     = bus_err_q & ~rst;
    assign state_o         = state_q;
endmodule

// File: doc/rv_ctrl_fsm.md
Name: rv_ctrl_fsm

Overview:
- Multi-cycle RV32 control unit: the producer side of the ALU interface.
- Sequences fetch, decode, execute, memory and writeback for a small RV32I subset.
- Drives ALU operation select, operand muxes, immediate select and write enables; consumes the instruction register, the memory ready handshake and the ALU zero flag.
- Sits between memory/IR and the datapath (regfile, ALU, ALUOut and PC registers).

Parameters:
- WAIT_LIMIT, 255: max cycles a memory request may wait for mem_ready before a bus-error trap (1..255).
- ALUC_W, 3: width of alu_control.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  current IR contents.
- mem_ready  in  1  memory completes current request this cycle.
- alu_zero  in  1  ALU result == 0 (combinational, same cycle).
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  write qualifier for mem_req.
- adr_src  out  1  0 = PC, 1 = ALUOut.
- ir_we  out  1  load IR and OLDPC.
- pc_we  out  1  load PC from result bus.
- reg_we  out  1  regfile write rd.
- alu_control  out  ALUC_W  0 = ADD, 1 = SUB, 2 = AND, 3 = SLL, 4 = CMP.
- alu_src_a  out  2  0 = PC, 1 = OLDPC, 2 = rs1.
- alu_src_b  out  2  0 = rs2, 1 = const 4, 2 = imm.
- imm_sel  out  2  0 = I, 1 = S, 2 = B, 3 = J.
- result_src  out  2  0 = ALUOut register, 1 = mem rdata, 2 = ALU result direct.
- illegal  out  1  sticky: illegal instruction trap.
- bus_err  out  1  sticky: memory timeout trap.

Behaviour:
- Reset and defaults:
  - While rst = 1, all outputs are 0 and the wait counter is cleared. The first cycle after rst falls is in FETCH.
  - Reset mid-operation aborts any request; no enable pulses.
  - Unlisted outputs are 0 in every state.
- FETCH:
  - mem_req = 1, adr_src = 0; stay until mem_ready.
  - On mem_ready, in the same cycle: ir_we = 1, pc_we = 1, a = PC, b = 4, ADD, result_src = 2. Next state is DECODE.
- DECODE:
  - a = OLDPC, b = imm, ADD (branch/jump target into ALUOut); imm_sel = J if opcode 1101111, else B.
  - Next state by opcode/funct:
    - 0110011 R-type → EXEC_R.
    - 0010011 I-arith → EXEC_I.
    - 0000011 with f3 = 010 (LW) → MEM_ADR.
    - 0100011 with f3 = 010 (SW) → MEM_ADR.
    - 1100011 with f3 000 or 001 → BRANCH.
    - 1101111 → JAL.
    - Anything else → TRAP with illegal = 1.
- EXEC_R: a = rs1, b = rs2. alu_control = ADD (f3 000, f7 0000000), SUB (f3 000, f7 0100000), AND (f3 111, f7 0), SLL (f3 001, f7 0). Other encodings are already rejected in DECODE. Next state is ALU_WB.
- EXEC_I: a = rs1, b = imm, imm_sel = I. ADDI (000), ANDI (111), SLLI (001, f7 must be 0, else illegal in DECODE). Next state is ALU_WB.
- ALU_WB: reg_we = 1, result_src = 0. Next state is FETCH.
- MEM_ADR: a = rs1, b = imm, ADD; imm_sel = I for LW, S for SW. Next state is MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_req = 1, adr_src = 1; on mem_ready go to MEM_WB.
- MEM_WB: reg_we = 1, result_src = 1. Next state is FETCH.
- MEM_WR: mem_req = 1, mem_we = 1, adr_src = 1; on mem_ready go to FETCH.
- BRANCH:
  - a = rs1, b = rs2, SUB; result_src = 0.
  - pc_we = alu_zero XOR f3[0] (BEQ taken on zero, BNE taken on nonzero). Next state is FETCH.
- JAL: pc_we = 1, result_src = 0 (target). Same cycle a = OLDPC, b = 4, ADD (link value into ALUOut). Next state is ALU_WB.
- Memory wait counter:
  - Counts cycles in FETCH/MEM_RD/MEM_WR with mem_ready = 0; cleared on state change.
  - When it reaches WAIT_LIMIT without mem_ready: TRAP with bus_err = 1, no enables pulsed.
  - mem_ready in the same cycle as the limit wins (normal completion).
- TRAP: all enables 0; illegal/bus_err held; exits only by rst.
- Cycle latency (zero-wait memory): R/I = 4, LW = 5, SW = 4, branch = 3, JAL = 4.

Decomposition:
- Package rv_ctrl_pkg holds:
  - state enum;
  - opcode constants;
  - funct3/funct7 constants;
  - ALU op codes (ADD = 0, SUB = 1, AND = 2, SLL = 3, CMP = 4), which the ALU also imports;
  - mux select encodings for alu_src_a, alu_src_b, imm_sel and result_src.
- Sub-module rv_instr_decode: combinational opcode/funct → {next-exec-state, alu op, imm_sel, legal}. The FSM keeps state register, wait counter and output logic.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), mem_ready always 1: the 4 cycles are FETCH, DECODE, EXEC_R, ALU_WB. In EXEC_R alu_control = 0. reg_we pulses once in cycle 4; pc_we pulses once in cycle 1.
- SUB (0x402081B3) then SLLI x3,x1,5 (0x00509193): alu_control 1, then 3 with alu_src_b = 2, imm_sel = 0.
- BEQ (0x00208463) with alu_zero = 1: pc_we = 1 in BRANCH. With alu_zero = 0: pc_we = 0. BNE (0x00209463) inverts both.
- LW (0x0000A183), mem_ready delayed 3 cycles: mem_req stays high 4 cycles with adr_src = 1, then reg_we with result_src = 1; total 8 cycles.
- Illegal 0xFFFFFFFF: illegal = 1 after DECODE, all enables 0 for 20 cycles. rst for 1 cycle → outputs 0, FETCH asserts mem_req.
- WAIT_LIMIT = 4, mem_ready held 0 in FETCH: bus_err = 1 after 4 cycles. Repeat with mem_ready = 1 on cycle 4: normal DECODE, bus_err = 0.
